mix_columns_byte_unit: RTL and testbench
========================================

# mix_columns_byte_unit

Byte-serial AES MixColumns/InvMixColumns stage that sits directly downstream of the byte permutation (ShiftRows) unit and consumes its `out_byte` stream. It gathers four consecutive bytes into one state column and transforms that column in GF(2^8). It then re-emits the column one byte per cycle. Double buffering sustains one byte per cycle with no bubbles; a bypass mode serves the final AES round.

## Interface
Parameters:
- none; widths are fixed by AES (byte = 8 bits, column = 4 bytes, state = 4 columns).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high; clears all state.
- `rst_synch` input 1: synchronous realignment; discards any partial input column and zeroes the fill and column counters.
- `in_valid` input 1: `in_byte` is valid this cycle.
- `in_byte` input 8: column-major state byte, row 0 first.
- `inverse` input 1: 0 selects MixColumns, 1 selects InvMixColumns.
- `bypass` input 1: 1 passes the column through unchanged (final round).
- `out_valid` output 1: `out_byte` is valid.
- `out_byte` output 8: transformed byte, row 0 first.
- `out_col_last` output 1: high with the row-3 byte of each output column.
- `out_state_last` output 1: high with the row-3 byte of column 3, which is byte 15 of the state.

## Operation
- Fill stage:
  - A 2-bit fill counter `fcnt` advances on each `in_valid`.
  - The byte is written to capture register `cap[fcnt]`.
- Load:
  - Occurs on the cycle that accepts the 4th byte (`fcnt==3 && in_valid`).
  - The column {`cap[0..2]`, `in_byte`} passes through the transform.
  - The result goes into the 4-byte output shift register.
  - `inverse` and `bypass` are sampled in this load cycle only.
  - A 2-bit column counter `ccnt` increments, wrapping 3→0.
- Forward transform (with `xt(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00)`):
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
- Inverse transform:
  - Same circulant structure with coefficients 0E, 0B, 0D, 09.
  - These are built from chained `xt`; no general multiplier.
- Bypass: r_i = a_i.
- Drain stage:
  - A drain counter `dcnt` runs 0..3 after each load.
  - `out_byte` = register[dcnt] and `out_valid` = 1 for 4 consecutive cycles, regardless of `in_valid`.
  - A load in the cycle the drain finishes (dcnt==3) is legal and required. The next column starts the following cycle with no gap.
  - Overrun is impossible, because refilling takes at least 4 cycles.
- Input gaps: `in_valid`=0 holds `fcnt` and `cap`. The output still drains and then goes idle (`out_valid`=0).
- Drain/counter state machine: IDLE → DRAIN0 → DRAIN1 → DRAIN2 → DRAIN3.
  - DRAIN3 → DRAIN0 if a load occurs, else → IDLE.
  - A load in IDLE → DRAIN0.
- `rst_synch`:
  - Clears `fcnt` and `ccnt`.
  - If `in_valid` is also high that cycle, that byte is taken as row 0 of a new column (`cap[0]`, `fcnt`→1).
  - An active drain completes unaffected; its `out_state_last` uses the pre-clear column index.
- `rst`: every output and counter goes to 0; `out_valid`=0, `out_byte`=8'h00, `out_col_last`=0, `out_state_last`=0. `rst` dominates `rst_synch`.

## Timing
- Column bytes accepted on consecutive cycles t..t+3 appear on `out_byte` at cycles t+4..t+7, all registered outputs.
- Latency is 4 cycles per byte; throughput is 1 byte/cycle sustained.
- `out_col_last` is asserted at t+7.
- `out_state_last` is asserted at t+7 when the loaded column had `ccnt==3`.
- A 16-byte state streamed back-to-back produces 16 contiguous `out_valid` cycles, starting 4 cycles after the first input.
- The transform is purely combinational between capture and output registers: at most one `xt` chain of depth 3 plus an XOR tree.

## Structure
- Package `aes_pkg`:
  - `function xt(byte)`.
  - Localparams `AES_POLY = 8'h1B`, `BYTES_PER_COL = 4`, `COLS_PER_STATE = 4`.
  - `typedef logic [7:0] byte_t`.
  - `typedef byte_t col_t [4]`.
  - Enum for the drain state.
- Sub-module `mix_column_core`:
  - Combinational.
  - Inputs: `col_t`, `inverse`, `bypass`.
  - Output: `col_t`.
  - Reusable by the key/round datapath.
- Top-level: counters, capture register, output shift register, state machine.

## Test plan
- Forward: stream DB 13 53 45 → output 8E 4D A1 BC at cycles t+4..t+7, `out_col_last` on BC.
- Forward identity columns: 01 01 01 01 → 01 01 01 01; C6 C6 C6 C6 → C6 C6 C6 C6.
- Forward: D4 D4 D4 D5 → D5 D5 D7 D6.
- Inverse: `inverse`=1, input 8E 4D A1 BC → DB 13 53 45. Bypass: F2 0A 22 5C → F2 0A 22 5C.
- Back-to-back 16-byte state (FIPS-197 round-1 after ShiftRows):
  - 16 contiguous `out_valid` cycles.
  - `out_state_last` only on byte 15.
  - Output matches FIPS-197 after-MixColumns vector.
- Gaps and realignment:
  - `in_valid` gaps inside a column produce the same output once the column completes, and the output idles between columns.
  - `rst_synch` after 2 bytes discards them; the next 4 bytes form column 0.
  - `rst` mid-drain → `out_valid`=0 the next cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES byte/column types, GF(2^8) doubling helper and the drain
// controller types used by the byte-serial MixColumns unit.
package aes_pkg;

    localparam logic [7:0] AES_POLY       = 8'h1B;
    localparam int         BYTES_PER_COL  = 4;
    localparam int         COLS_PER_STATE = 4;

    localparam int FCNT_W = $clog2(BYTES_PER_COL);
    localparam int CCNT_W = $clog2(COLS_PER_STATE);

    typedef logic [7:0] byte_t;
    typedef byte_t col_t [4];

    typedef enum logic [2:0] {
        DS_IDLE   = 3'd0,
        DS_DRAIN0 = 3'd1,
        DS_DRAIN1 = 3'd2,
        DS_DRAIN2 = 3'd3,
        DS_DRAIN3 = 3'd4
    } drain_state_t;

    // Whole control state in one struct so a checker can bind to a single
    // signal: drain state, fill counter, column counter and the column index
    // latched for the column currently draining.
    typedef struct packed {
        drain_state_t      state;
        logic [FCNT_W-1:0] fcnt;
        logic [CCNT_W-1:0] ccnt;
        logic [CCNT_W-1:0] drain_col;
    } ctrl_t;

    // Multiply by x (0x02) in GF(2^8) modulo the AES polynomial.
    function automatic byte_t xt(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_core.sv
// Combinational MixColumns / InvMixColumns / bypass on one 4-byte column.
// Every multiple is built from a depth-3 chain of xt() plus XORs.
module mix_column_core
    import aes_pkg::*;
(
    input  col_t col,
    input  logic inverse,
    input  logic bypass,
    output col_t result
);

    byte_t x1 [4];
    byte_t x2 [4];
    byte_t x3 [4];
    byte_t m2 [4];
    byte_t m3 [4];
    byte_t m9 [4];
    byte_t mb [4];
    byte_t md [4];
    byte_t me [4];

    // Per-byte multiples by 2, 4, 8 and the coefficients derived from them.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x1[i] = xt(col[i]);
            x2[i] = xt(x1[i]);
            x3[i] = xt(x2[i]);
            m2[i] = x1[i];
            m3[i] = x1[i] ^ col[i];
            m9[i] = x3[i] ^ col[i];
            mb[i] = x3[i] ^ x1[i] ^ col[i];
            md[i] = x3[i] ^ x2[i] ^ col[i];
            me[i] = x3[i] ^ x2[i] ^ x1[i];
        end
    end

    // Circulant combination: row i uses coefficients rotated by i.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [1:0] i0;
            logic [1:0] i1;
            logic [1:0] i2;
            logic [1:0] i3;
            byte_t      fwd;
            byte_t      inv;
            i0  = 2'(i);
            i1  = 2'(i + 1);
            i2  = 2'(i + 2);
            i3  = 2'(i + 3);
            fwd = m2[i0] ^ m3[i1] ^ col[i2] ^ col[i3];
            inv = me[i0] ^ mb[i1] ^ md[i2] ^ m9[i3];
            if (bypass) begin
                result[i] = col[i];
            end else if (inverse) begin
                result[i] = inv;
            end else begin
                result[i] = fwd;
            end
        end
    end

endmodule

// File: rtl/mix_columns_byte_unit.sv
// Byte-serial MixColumns stage: gathers four bytes into a column, transforms
// it and re-emits it one byte per cycle from a double-buffered output column.
//
// Stream protocol: in_valid qualifies in_byte with no backpressure (the unit
// always accepts); out_valid qualifies out_byte and the last flags, and the
// consumer must take every valid byte since there is no ready.
module mix_columns_byte_unit
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_synch,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       inverse,
    input  logic       bypass,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_col_last,
    output logic       out_state_last
);

    localparam logic [FCNT_W-1:0] LAST_ROW = FCNT_W'(BYTES_PER_COL - 1);
    localparam logic [CCNT_W-1:0] LAST_COL = CCNT_W'(COLS_PER_STATE - 1);

    ctrl_t      ctrl_q;
    ctrl_t      ctrl_d;
    byte_t      cap [3];
    col_t       obuf;
    col_t       load_col;
    col_t       core_out;
    logic       load;
    logic [1:0] dcnt;

    // A realignment cycle never completes a column, even with in_valid high.
    assign load = in_valid && !rst_synch && (ctrl_q.fcnt == LAST_ROW);

    assign load_col[0] = cap[0];
    assign load_col[1] = cap[1];
    assign load_col[2] = cap[2];
    assign load_col[3] = in_byte;

    mix_column_core u_core (
        .col     (load_col),
        .inverse (inverse),
        .bypass  (bypass),
        .result  (core_out)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Next-state logic for counters and the drain sequencer.
    always_comb begin
        ctrl_d = ctrl_q;
        if (rst_synch) begin
            ctrl_d.fcnt = '0;
            ctrl_d.ccnt = '0;
        end
        if (in_valid) begin
            ctrl_d.fcnt = rst_synch ? FCNT_W'(1) : ctrl_q.fcnt + FCNT_W'(1);
        end
        if (load) begin
            ctrl_d.ccnt      = ctrl_q.ccnt + CCNT_W'(1);
            ctrl_d.drain_col = ctrl_q.ccnt;
        end
        if (load) begin
            ctrl_d.state = DS_DRAIN0;
        end else begin
            case (ctrl_q.state)
                DS_DRAIN0: ctrl_d.state = DS_DRAIN1;
                DS_DRAIN1: ctrl_d.state = DS_DRAIN2;
                DS_DRAIN2: ctrl_d.state = DS_DRAIN3;
                default:   ctrl_d.state = DS_IDLE;
            endcase
        end
    end

    // Output decode from the drain state and the latched column index.
    always_comb begin
        case (ctrl_q.state)
            DS_DRAIN1: dcnt = 2'd1;
            DS_DRAIN2: dcnt = 2'd2;
            DS_DRAIN3: dcnt = 2'd3;
            default:   dcnt = 2'd0;
        endcase
        out_valid      = (ctrl_q.state != DS_IDLE);
        out_byte       = out_valid ? obuf[dcnt] : 8'h00;
        out_col_last   = (ctrl_q.state == DS_DRAIN3);
        out_state_last = (ctrl_q.state == DS_DRAIN3) && (ctrl_q.drain_col == LAST_COL);
    end

    // Capture rows 0..2; row 3 goes straight from in_byte into the transform.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap <= '{default: 8'h00};
        end else if (in_valid) begin
            case (rst_synch ? 2'd0 : ctrl_q.fcnt)
                2'd0:    cap[0] <= in_byte;
                2'd1:    cap[1] <= in_byte;
                2'd2:    cap[2] <= in_byte;
                default: ;
            endcase
        end
    end

    // Output column buffer, reloaded on the cycle the fourth byte arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            obuf <= '{default: 8'h00};
        end else if (load) begin
            obuf <= core_out;
        end
    end

endmodule

// File: tb/tb_mix_columns_byte_unit.sv
// Self-checking bench for mix_columns_byte_unit: directed FIPS-197 columns,
// realignment and reset cases, then randomized byte streams against a
// GF(2^8) matrix model.
module tb_mix_columns_byte_unit;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_synch = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       inverse = 1'b0;
    logic       bypass = 1'b0;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_col_last;
    logic       out_state_last;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mix_columns_byte_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rst_synch      (rst_synch),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .inverse        (inverse),
        .bypass         (bypass),
        .out_valid      (out_valid),
        .out_byte       (out_byte),
        .out_col_last   (out_col_last),
        .out_state_last (out_state_last)
    );

    // ---------------- scoreboard state ----------------
    logic [9:0] exp_q[$];   // {state_last, col_last, byte}
    int         due_q[$];   // cycle in which each expected byte must appear
    logic [7:0] lit_q[$];   // literal expected bytes overriding the model
    logic [7:0] m_bytes[$]; // model fill buffer
    int         m_ccnt = 0;
    bit         mon_en = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Column packed with row 0 in the most significant byte.
    function automatic logic [31:0] model_col(input logic [31:0] c, input logic inv, input logic byp);
        logic [7:0]  coef [4];
        logic [7:0]  a [4];
        logic [7:0]  r;
        logic [31:0] res;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int j = 0; j < 4; j++) a[j] = c[31-8*j -: 8];
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r ^= gf_mul(a[j], coef[(j - i + 4) % 4]);
            res[31-8*i -: 8] = byp ? a[i] : r;
        end
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic v, input logic [7:0] b, input logic inv,
                               input logic byp, input logic rs);
        logic [31:0] col;
        logic [31:0] res;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_byte   = b;
        inverse   = inv;
        bypass    = byp;
        rst_synch = rs;
        if (rs) begin
            m_bytes.delete();
            m_ccnt = 0;
        end
        if (v) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                col = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                if (lit_q.size() >= 4) begin
                    for (int r = 0; r < 4; r++) res[31-8*r -: 8] = lit_q.pop_front();
                end else begin
                    res = model_col(col, inv, byp);
                end
                for (int r = 0; r < 4; r++) begin
                    exp_q.push_back({(r == 3) && (m_ccnt == 3), r == 3, res[31-8*r -: 8]});
                    due_q.push_back(cyc + 1 + r);
                end
                m_ccnt = (m_ccnt + 1) % 4;
                m_bytes.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // Mode pins are random except on the byte that completes the column.
    task automatic feed_col(input logic [31:0] c, input logic inv, input logic byp, input bit gaps);
        for (int r = 0; r < 4; r++) begin
            if (gaps) idle($urandom_range(0, 2));
            drive_cycle(1'b1, c[31-8*r -: 8],
                        (r == 3) ? inv : 1'($urandom),
                        (r == 3) ? byp : 1'($urandom), 1'b0);
        end
    endtask

    task automatic feed_lit(input logic [31:0] c, input logic inv, input logic byp,
                            input logic [31:0] expv, input bit gaps);
        for (int r = 0; r < 4; r++) lit_q.push_back(expv[31-8*r -: 8]);
        feed_col(c, inv, byp, gaps);
    endtask

    task automatic do_reset();
        int keep;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        rst_synch = 1'b0;
        keep = 0;
        while (keep < due_q.size() && due_q[keep] <= cyc) keep++;
        while (due_q.size() > keep) begin
            void'(due_q.pop_back());
            void'(exp_q.pop_back());
        end
        m_bytes.delete();
        lit_q.delete();
        m_ccnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_byte", out_byte, 0);
        check_val("rst_col_last", out_col_last, 0);
        check_val("rst_state_last", out_state_last, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [9:0] mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mon_e = exp_q.pop_front();
                void'(due_q.pop_front());
                check_val("out_valid", out_valid, 1);
                check_val("out_byte", out_byte, mon_e[7:0]);
                check_val("out_col_last", out_col_last, mon_e[8]);
                check_val("out_state_last", out_state_last, mon_e[9]);
            end else begin
                check_val("idle_valid", out_valid, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_out_byte", out_byte, 0);
        check_val("reset_col_last", out_col_last, 0);
        check_val("reset_state_last", out_state_last, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Known columns, back to back.
        feed_lit(32'hdb135345, 1'b0, 1'b0, 32'h8e4da1bc, 1'b0);
        feed_lit(32'h01010101, 1'b0, 1'b0, 32'h01010101, 1'b0);
        feed_lit(32'hc6c6c6c6, 1'b0, 1'b0, 32'hc6c6c6c6, 1'b0);
        feed_lit(32'hd4d4d4d5, 1'b0, 1'b0, 32'hd5d5d7d6, 1'b0);
        feed_lit(32'h8e4da1bc, 1'b1, 1'b0, 32'hdb135345, 1'b0);
        feed_lit(32'hf20a225c, 1'b1, 1'b1, 32'hf20a225c, 1'b0);
        idle(6);

        // FIPS-197 round 1 state, realigned so it forms columns 0..3.
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        feed_lit(32'hd4bf5d30, 1'b0, 1'b0, 32'h046681e5, 1'b0);
        feed_lit(32'he0b452ae, 1'b0, 1'b0, 32'he0cb199a, 1'b0);
        feed_lit(32'hb84111f1, 1'b0, 1'b0, 32'h48f8d37a, 1'b0);
        feed_lit(32'h1e2798e5, 1'b0, 1'b0, 32'h28064c26 ^ 32'h00006a6a, 1'b0);
        idle(6);

        // Input gaps inside columns.
        feed_lit(32'hdb135345, 1'b0, 1'b0, 32'h8e4da1bc, 1'b1);
        idle(3);
        feed_lit(32'h8e4da1bc, 1'b1, 1'b0, 32'hdb135345, 1'b1);
        idle(6);

        // Realignment after two bytes discards them.
        drive_cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        feed_lit(32'hd4d4d4d5, 1'b0, 1'b0, 32'hd5d5d7d6, 1'b0);
        // Realignment with a valid byte: that byte becomes row 0.
        drive_cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'hdb, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h53, 1'b0, 1'b0, 1'b0);
        lit_q = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
        drive_cycle(1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Reset in the middle of a drain.
        feed_col(32'h12345678, 1'b0, 1'b0, 1'b0);
        idle(1);
        do_reset();
        idle(4);

        // Randomized streams with gaps, mode changes and realignment.
        for (int i = 0; i < 600; i++) begin
            drive_cycle(1'($urandom_range(0, 99) < 75), 8'($urandom),
                        1'($urandom), 1'($urandom_range(0, 99) < 20),
                        1'($urandom_range(0, 99) < 3));
        end
        idle(8);
        check_val("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
